// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_rd_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DATA} state_e;

  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic dreq;
  logic if_pend;
  logic dm_pend;
  logic starve_full;

  // A port whose ack is showing this cycle is masked so the same request is not served twice.
  assign dreq        = dm_rd_i | dm_wr_i;
  assign if_pend     = if_req_i & ~if_ack_q;
  assign dm_pend     = dreq & ~dm_ack_q;
  assign starve_full = (starve_q == MAX_CNT);

  // Arbitration, transaction tracking and starvation counting.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A completion with nothing outstanding is a protocol error.
        if (mem_ack_i) err_d = 1'b1;
        if (if_pend && (starve_full || !dm_pend)) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          starve_d   = '0;
        end else begin
          if (if_req_i && !starve_full) starve_d = starve_q + 1'b1;
          if (dm_pend) begin
            state_d     = ST_DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_wr_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            // Read and write together resolve to a write, flagged as an error.
            if (dm_rd_i && dm_wr_i) err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (mem_ack_i) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end
      ST_DATA: begin
        if (if_req_i && !starve_full) starve_d = starve_q + 1'b1;
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          dm_ack_d  = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign stall_o     = (if_req_i & ~if_ack_q) | (dreq & ~dm_ack_q);
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] I1 = 32'h8C220004;
  localparam logic [31:0] I2 = 32'h11112222;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] W2 = 32'h12345678;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic if_ack_o;
  logic [31:0] if_rdata_o;
  logic dm_rd = 1'b0;
  logic dm_wr = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic mem_req_o;
  logic mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic stall_o;
  logic err_o;

  int vectors = 0;
  int miscompares = 0;
  int wait_left = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_rd_i(dm_rd), .dm_wr_i(dm_wr), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ifr; logic [31:0] ifa; logic rd; logic wr; logic [31:0] da; logic [31:0] dw;
    logic mack; logic [31:0] mrd;
    logic req; logic we; logic [31:0] addr; logic [31:0] wd; logic ifack; logic dmack;
    logic [31:0] ifrd; logic [31:0] dmrd; logic stall; logic err;
  } vec_t;
  vec_t tbl [22];

  // Reference model: who owns the memory, what was latched, and how long fetch has waited.
  int m_owner;  // 0 none, 1 fetch, 2 data
  int m_starve;
  bit m_req, m_we, m_if_ack, m_dm_ack, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_req = 0; m_we = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
  endtask

  task automatic model_step();
    bit f_want, d_want;
    f_want = if_req && !m_if_ack;
    d_want = (dm_rd || dm_wr) && !m_dm_ack;
    m_if_ack = 0; m_dm_ack = 0; m_err = 0;
    if (m_owner == 0) begin
      if (mem_ack) m_err = 1;
      if (f_want && (m_starve == MAX_WAIT || !d_want)) begin
        m_owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_starve = 0;
      end else begin
        if (if_req) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
        if (d_want) begin
          m_owner = 2; m_req = 1; m_we = dm_wr; m_addr = dm_addr; m_wdata = dm_wdata;
          if (dm_rd && dm_wr) m_err = 1;
        end
      end
    end else begin
      if (m_owner == 2 && if_req) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      if (mem_ack) begin
        if (m_owner == 1) begin
          m_if_ack = 1; m_if_rdata = mem_rdata;
        end else begin
          m_dm_ack = 1;
          if (!m_we) m_dm_rdata = mem_rdata;
        end
        m_req = 0; m_owner = 0;
      end
    end
  endtask

  // Inputs already applied at the falling edge; compare, advance model, move to next falling edge.
  task automatic run_model_cycle(input string tag);
    bit exp_stall;
    #1;
    exp_stall = (if_req && !m_if_ack) || ((dm_rd || dm_wr) && !m_dm_ack);
    chk({tag, ".mem_req"}, 32'(mem_req_o), 32'(m_req));
    chk({tag, ".mem_we"}, 32'(mem_we_o), 32'(m_we));
    chk({tag, ".mem_addr"}, mem_addr_o, m_addr);
    chk({tag, ".mem_wdata"}, mem_wdata_o, m_wdata);
    chk({tag, ".if_ack"}, 32'(if_ack_o), 32'(m_if_ack));
    chk({tag, ".dm_ack"}, 32'(dm_ack_o), 32'(m_dm_ack));
    chk({tag, ".if_rdata"}, if_rdata_o, m_if_rdata);
    chk({tag, ".dm_rdata"}, dm_rdata_o, m_dm_rdata);
    chk({tag, ".err"}, 32'(err_o), 32'(m_err));
    chk({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory responder: acks after a number of wait cycles; negative fixed means random waits
  // plus occasional stray acks while nothing is outstanding.
  task automatic drive_mem(input int fixed);
    mem_rdata = $urandom;
    if (m_req) begin
      if (wait_left <= 0) begin
        mem_ack = 1'b1;
        wait_left = (fixed >= 0) ? fixed : int'($urandom_range(0, 3));
      end else begin
        mem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      mem_ack = (fixed < 0) && ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
    #1;
    chk("reset.mem_req", 32'(mem_req_o), 32'(0));
    chk("reset.mem_we", 32'(mem_we_o), 32'(0));
    chk("reset.mem_addr", mem_addr_o, Z);
    chk("reset.acks", {30'b0, if_ack_o, dm_ack_o}, Z);
    chk("reset.rdata", if_rdata_o | dm_rdata_o | mem_wdata_o, Z);
    chk("reset.err", 32'(err_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n_if, n_dm;
    logic r0, r1;
    int sel;
    //        ifr ifa        rd wr da         dw  mack mrd           req we addr      wd  ifack dmack ifrd dmrd stall err
    tbl[0]  = '{H, 32'h40, L, L, Z,       Z,  L, Z,            L, L, Z,       Z,  L, L, Z,  Z,  H, L};
    tbl[1]  = '{H, 32'h40, L, L, Z,       Z,  H, I1,           H, L, 32'h40,  Z,  L, L, Z,  Z,  H, L};
    tbl[2]  = '{L, Z,      L, L, Z,       Z,  L, Z,            L, L, 32'h40,  Z,  H, L, I1, Z,  L, L};
    tbl[3]  = '{H, 32'h44, L, H, 32'h100, DB, L, Z,            L, L, 32'h40,  Z,  L, L, I1, Z,  H, L};
    tbl[4]  = '{H, 32'h44, L, H, 32'h100, DB, H, Z,            H, H, 32'h100, DB, L, L, I1, Z,  H, L};
    tbl[5]  = '{H, 32'h44, L, H, 32'h100, DB, L, Z,            L, H, 32'h100, DB, L, H, I1, Z,  H, L};
    tbl[6]  = '{H, 32'h44, L, L, Z,       Z,  H, I2,           H, L, 32'h44,  DB, L, L, I1, Z,  H, L};
    tbl[7]  = '{L, Z,      L, L, Z,       Z,  L, Z,            L, L, 32'h44,  DB, H, L, I2, Z,  L, L};
    tbl[8]  = '{L, Z,      H, H, 32'h200, W2, L, Z,            L, L, 32'h44,  DB, L, L, I2, Z,  H, L};
    tbl[9]  = '{L, Z,      H, H, 32'h200, W2, L, Z,            H, H, 32'h200, W2, L, L, I2, Z,  H, H};
    tbl[10] = '{L, Z,      H, H, 32'h200, W2, H, 32'hFFFFFFFF, H, H, 32'h200, W2, L, L, I2, Z,  H, L};
    tbl[11] = '{L, Z,      L, L, Z,       Z,  L, Z,            L, H, 32'h200, W2, L, H, I2, Z,  L, L};
    tbl[12] = '{L, Z,      L, L, Z,       Z,  H, Z,            L, H, 32'h200, W2, L, L, I2, Z,  L, L};
    tbl[13] = '{L, Z,      L, L, Z,       Z,  L, Z,            L, H, 32'h200, W2, L, L, I2, Z,  L, H};
    tbl[14] = '{L, Z,      L, L, Z,       Z,  L, Z,            L, H, 32'h200, W2, L, L, I2, Z,  L, L};
    tbl[15] = '{L, Z,      H, L, 32'h300, Z,  L, Z,            L, H, 32'h200, W2, L, L, I2, Z,  H, L};
    tbl[16] = '{L, Z,      H, L, 32'h300, Z,  L, Z,            H, L, 32'h300, Z,  L, L, I2, Z,  H, L};
    tbl[17] = '{L, Z,      H, L, 32'h300, Z,  L, Z,            H, L, 32'h300, Z,  L, L, I2, Z,  H, L};
    tbl[18] = '{L, Z,      H, L, 32'h300, Z,  L, Z,            H, L, 32'h300, Z,  L, L, I2, Z,  H, L};
    tbl[19] = '{L, Z,      H, L, 32'h300, Z,  H, A5,           H, L, 32'h300, Z,  L, L, I2, Z,  H, L};
    tbl[20] = '{L, Z,      L, L, Z,       Z,  L, Z,            L, L, 32'h300, Z,  L, H, I2, A5, L, L};
    tbl[21] = '{L, Z,      L, L, Z,       Z,  L, Z,            L, L, 32'h300, Z,  L, L, I2, A5, L, L};

    do_reset();

    // Directed table: fetch only, simultaneous requests, error cases, wait states.
    for (int i = 0; i < 22; i++) begin
      if_req = tbl[i].ifr; if_addr = tbl[i].ifa; dm_rd = tbl[i].rd; dm_wr = tbl[i].wr;
      dm_addr = tbl[i].da; dm_wdata = tbl[i].dw; mem_ack = tbl[i].mack; mem_rdata = tbl[i].mrd;
      #1;
      chk($sformatf("t%0d.mem_req", i), 32'(mem_req_o), 32'(tbl[i].req));
      chk($sformatf("t%0d.mem_we", i), 32'(mem_we_o), 32'(tbl[i].we));
      chk($sformatf("t%0d.mem_addr", i), mem_addr_o, tbl[i].addr);
      chk($sformatf("t%0d.mem_wdata", i), mem_wdata_o, tbl[i].wd);
      chk($sformatf("t%0d.if_ack", i), 32'(if_ack_o), 32'(tbl[i].ifack));
      chk($sformatf("t%0d.dm_ack", i), 32'(dm_ack_o), 32'(tbl[i].dmack));
      chk($sformatf("t%0d.if_rdata", i), if_rdata_o, tbl[i].ifrd);
      chk($sformatf("t%0d.dm_rdata", i), dm_rdata_o, tbl[i].dmrd);
      chk($sformatf("t%0d.stall", i), 32'(stall_o), 32'(tbl[i].stall));
      chk($sformatf("t%0d.err", i), 32'(err_o), 32'(tbl[i].err));
      @(posedge clk);
      @(negedge clk);
    end

    // Reset in the middle of a data access: request drops at once, nothing completes afterwards.
    if_req = 0; dm_rd = 0; mem_ack = 0;
    dm_wr = 1; dm_addr = 32'h500; dm_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst.req_before", 32'(mem_req_o), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst.req_async", 32'(mem_req_o), 32'(0));
    chk("midrst.addr_cleared", mem_addr_o, Z);
    chk("midrst.we_cleared", 32'(mem_we_o), 32'(0));
    dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ack = 0;
      run_model_cycle($sformatf("midrst.c%0d", i));
    end

    // Data port hammering with slow memory while a fetch stays pending.
    do_reset();
    wait_left = 5;
    n_if = 0; n_dm = 0;
    for (int i = 0; i < 60; i++) begin
      if_req = 1; if_addr = 32'h80; dm_rd = 1; dm_addr = 32'h600;
      drive_mem(5);
      if (if_ack_o) n_if++;
      if (dm_ack_o) n_dm++;
      run_model_cycle($sformatf("starve.c%0d", i));
    end
    chk("starve.fetch_progress", 32'(n_if >= 3), 32'(1));
    chk("starve.data_progress", 32'(n_dm >= 3), 32'(1));

    // Randomized traffic against the reference model.
    do_reset();
    wait_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      end else if (m_if_ack) begin
        if ($urandom_range(0, 1) == 0) if_req = 0; else if_addr = $urandom;
      end
      if (!(dm_rd || dm_wr)) begin
        if ($urandom_range(0, 2) == 0) begin
          sel = int'($urandom_range(0, 7));
          r0 = (sel < 4) || (sel == 7);
          r1 = (sel >= 4);
          dm_rd = r0; dm_wr = r1; dm_addr = $urandom; dm_wdata = $urandom;
        end
      end else if (m_dm_ack) begin
        if ($urandom_range(0, 1) == 0) begin
          dm_rd = 0; dm_wr = 0;
        end else begin
          dm_addr = $urandom; dm_wdata = $urandom;
        end
      end
      drive_mem(-1);
      run_model_cycle($sformatf("rnd.c%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
